mips_bus_arbiter: RTL and testbench

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

---
 rtl/mips_bus_pkg.sv | 19 +
 rtl/mips_bus_stall_timer.sv | 32 +++
 rtl/mips_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and default parameters for the MIPS instruction/data bus arbiter.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam logic [31:0] ERR_READDATA_DEF   = 32'hDEADBEEF;

endpackage

// File: rtl/mips_bus_stall_timer.sv
// Counts slave stall cycles of the current transfer; expired fires in the
// stall cycle that brings the count to TIMEOUT_CYCLES.
module mips_bus_stall_timer
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Arbitrates a MIPS fetch port and data port onto one Avalon-style memory slave,
// with alternating priority, a local zero-page read and a stall timeout.
//
// state | meaning
// IDLE  | waiting for a request; grants and registers the command
// BUSY  | strobe on the slave until accepted or timed out
// RDATA | slave read data valid, captured into the response register
// RESP  | one-cycle response to the granted port
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [31:0] ERR_READDATA   = ERR_READDATA_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        bus_error
);

  state_e      r_state, w_next;
  port_e       r_grant, r_last, w_port;
  logic        r_read, r_write, r_bus_error;
  logic [31:0] r_address, r_writedata, r_resp;
  logic [3:0]  r_byteenable;

  logic        w_req_i, w_req_d, w_pick_i, w_pick_d;
  logic        w_is_write, w_local;
  logic [31:0] w_addr;
  logic        w_timer_clear, w_timer_en, w_expired;

  // Contention goes to the port that was not granted last.
  always_comb begin
    w_req_i    = i_read;
    w_req_d    = d_read | d_write;
    w_pick_d   = w_req_d && (!w_req_i || (r_last == PORT_I));
    w_pick_i   = w_req_i && !w_pick_d;
    w_port     = w_pick_d ? PORT_D : PORT_I;
    w_addr     = w_pick_d ? d_address : i_address;
    w_is_write = w_pick_d && d_write;
    w_local    = !w_is_write && (w_addr == 32'h0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_i || w_pick_d) begin
          w_next = w_local ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!waitrequest) begin
          w_next = r_write ? RESP : RDATA;
        end else if (w_expired) begin
          w_next = RESP;
        end
      end
      RDATA:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_timer_clear = (r_state == IDLE) && (w_next == BUSY);
  assign w_timer_en    = (r_state == BUSY) && waitrequest;

  mips_bus_stall_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (w_timer_clear),
    .enable (w_timer_en),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant      <= PORT_I;
      r_last       <= PORT_D;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= '0;
      r_writedata  <= '0;
      r_byteenable <= '0;
      r_resp       <= '0;
      r_bus_error  <= 1'b0;
    end else begin
      r_bus_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_i || w_pick_d) begin
            r_grant   <= w_port;
            r_last    <= w_port;
            r_address <= w_addr;
            if (w_local) begin
              r_resp <= '0;
            end else begin
              r_read       <= !w_is_write;
              r_write      <= w_is_write;
              r_writedata  <= w_is_write ? d_writedata : 32'h0;
              // An all-zero lane mask on a store means a full-word store.
              r_byteenable <= (w_is_write && (d_byteenable != 4'b0000)) ? d_byteenable : 4'b1111;
            end
          end
        end
        BUSY: begin
          if (!waitrequest) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= '0;
          end else if (w_expired) begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_bus_error <= 1'b1;
            r_resp      <= ERR_READDATA;
          end
        end
        RDATA: begin
          r_resp <= readdata;
        end
        default: begin
        end
      endcase
    end
  end

  assign address    = r_address;
  assign writedata  = r_writedata;
  assign read       = r_read;
  assign write      = r_write;
  assign byteenable = r_byteenable;
  assign bus_error  = r_bus_error;

  assign i_waitrequest = !((r_state == RESP) && (r_grant == PORT_I));
  assign d_waitrequest = !((r_state == RESP) && (r_grant == PORT_D));
  assign i_readdata    = ((r_state == RESP) && (r_grant == PORT_I)) ? r_resp : 32'h0;
  assign d_readdata    = ((r_state == RESP) && (r_grant == PORT_D)) ? r_resp : 32'h0;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: a vector table of single transfers plus
// hand sequences for contention, mid-transfer changes, timeout and reset.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address, d_writedata;
  logic        d_read, d_write;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] address, writedata;
  logic        read, write;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [16];
  int   stall_left = 0;
  logic hang = 1'b0;

  typedef struct {
    logic        fetch;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stall;
    int          exp_lat;
    logic [31:0] exp_rdata;
    int          exp_stb;
    logic [3:0]  exp_be;
    logic        exp_wr;
  } vec_t;

  vec_t vecs[10];

  mips_bus_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_address    (i_address),
    .i_read       (i_read),
    .i_waitrequest(i_waitrequest),
    .i_readdata   (i_readdata),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_byteenable (d_byteenable),
    .d_waitrequest(d_waitrequest),
    .d_readdata   (d_readdata),
    .address      (address),
    .writedata    (writedata),
    .read         (read),
    .write        (write),
    .byteenable   (byteenable),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .bus_error    (bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock; the slave model answers from what it saw just before the edge.
  task automatic step();
    logic        was_strobe, was_read, acc;
    logic [31:0] a;
    was_strobe = read | write;
    was_read   = read;
    acc        = was_strobe && !waitrequest;
    a          = address;
    @(posedge clk);
    #1;
    readdata = (acc && was_read) ? mem[a[5:2]] : 32'h0BAD0BAD;
    if (was_strobe && waitrequest && (stall_left > 0)) stall_left--;
    waitrequest = hang || (stall_left != 0);
  endtask

  task automatic release_all();
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, output int lat, output logic [31:0] rd, output int nstb,
                         output logic [3:0] be_seen, output logic wr_seen, output logic [31:0] wd_seen,
                         output int nberr, output logic other_low);
    lat = -1; rd = 32'hX; nstb = 0; be_seen = 4'hX; wr_seen = 1'bX; wd_seen = 32'hX;
    nberr = 0; other_low = 1'b0;
    stall_left  = v.stall;
    waitrequest = (v.stall != 0);
    if (v.fetch) begin
      i_address = v.addr;
      i_read    = 1'b1;
    end else begin
      d_address    = v.addr;
      d_writedata  = v.wdata;
      d_byteenable = v.be;
      d_read       = v.rd;
      d_write      = v.wr;
    end
    for (int c = 1; c <= 400; c++) begin
      step();
      if (read | write) begin
        nstb++;
        be_seen = byteenable;
        wr_seen = write;
        wd_seen = writedata;
      end
      if (bus_error) nberr++;
      if (v.fetch ? !d_waitrequest : !i_waitrequest) other_low = 1'b1;
      if (v.fetch ? !i_waitrequest : !d_waitrequest) begin
        lat = c;
        rd  = v.fetch ? i_readdata : d_readdata;
        break;
      end
    end
    release_all();
    step();
  endtask

  // Steps until every raised request has been answered, releasing each on its response.
  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (!i_waitrequest) i_read = 1'b0;
      if (!d_waitrequest) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
      if (!i_read && !d_read && !d_write) begin
        done = 1'b1;
        break;
      end
    end
    chk({nm, "_drained"}, 32'(done), 32'd1);
    step();
  endtask

  initial begin
    int          lat, nstb, nberr;
    logic [31:0] rd, wd_seen;
    logic [3:0]  be_seen;
    logic        wr_seen, other_low;
    int          rd_c, wr_c, ir_c, dr_c, berr_c, berr_n;
    logic [3:0]  cbe;
    logic [31:0] cwd, idat, ddat;
    vec_t        v;

    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);

    //           fetch rd    wr    addr          wdata         be     st lat rdata         stb be     wr
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'hBFC00000, 32'h0,        4'h0,  0, 3, 32'h10000000, 1, 4'hF,  1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h00000014, 32'h0,        4'h0,  2, 5, 32'h10000005, 3, 4'hF,  1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h00000100, 32'hCAFE0001, 4'h3,  0, 2, 32'h0,        1, 4'h3,  1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h00000104, 32'h12345678, 4'h0,  0, 2, 32'h0,        1, 4'hF,  1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h00000020, 32'hA5A5A5A5, 4'hC,  1, 3, 32'h0,        2, 4'hC,  1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h00000008, 32'h0,        4'h1,  0, 3, 32'h10000002, 1, 4'hF,  1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h0,        4'hF,  0, 1, 32'h0,        0, 4'hF,  1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h0,        4'h0,  0, 1, 32'h0,        0, 4'hF,  1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 32'h00000030, 32'h00C0FFEE, 4'hF,  3, 5, 32'h0,        4, 4'hF,  1'b1};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 32'h0000003C, 32'h0,        4'h0,  1, 4, 32'h1000000F, 2, 4'hF,  1'b0};

    reset_n = 1'b0;
    i_address = '0; i_read = 1'b0;
    d_address = '0; d_writedata = '0; d_read = 1'b0; d_write = 1'b0; d_byteenable = '0;
    waitrequest = 1'b0; readdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read",  32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_be",    32'(byteenable), 32'd0);
    chk("rst_iwait", 32'(i_waitrequest), 32'd1);
    chk("rst_dwait", 32'(d_waitrequest), 32'd1);
    chk("rst_berr",  32'(bus_error), 32'd0);
    reset_n = 1'b1;
    step();
    chk("idle_iwait", 32'(i_waitrequest), 32'd1);
    chk("idle_dwait", 32'(d_waitrequest), 32'd1);

    for (int k = 0; k < 10; k++) begin
      v = vecs[k];
      run_txn(v, lat, rd, nstb, be_seen, wr_seen, wd_seen, nberr, other_low);
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_strobes", k), 32'(nstb), 32'(v.exp_stb));
      chk($sformatf("v%0d_other_wait", k), 32'(other_low), 32'd0);
      chk($sformatf("v%0d_berr", k), 32'(nberr), 32'd0);
      if (!v.exp_wr) chk($sformatf("v%0d_rdata", k), rd, v.exp_rdata);
      if (v.exp_stb > 0) begin
        chk($sformatf("v%0d_be", k), 32'(be_seen), 32'(v.exp_be));
        chk($sformatf("v%0d_is_write", k), 32'(wr_seen), 32'(v.exp_wr));
        if (v.exp_wr) chk($sformatf("v%0d_wdata", k), wd_seen, v.wdata);
      end
    end

    // Contention: fetch first after reset, then the store, then fetch wins again.
    stall_left = 0; waitrequest = 1'b0;
    i_address = 32'h4; i_read = 1'b1;
    d_address = 32'h40; d_writedata = 32'hF3; d_byteenable = 4'h0; d_write = 1'b1;
    rd_c = -1; wr_c = -1; ir_c = -1; dr_c = -1; cbe = 4'hX; cwd = 32'hX; idat = 32'hX;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (read && rd_c < 0) rd_c = c;
      if (write && wr_c < 0) begin
        wr_c = c; cbe = byteenable; cwd = writedata;
      end
      if (!i_waitrequest && ir_c < 0) begin
        ir_c = c; idat = i_readdata; i_read = 1'b0;
      end
      if (!d_waitrequest && dr_c < 0) begin
        dr_c = c; d_write = 1'b0;
      end
      if (ir_c > 0 && dr_c > 0) break;
    end
    chk("arb_read_cycle",  32'(rd_c), 32'd1);
    chk("arb_i_resp",      32'(ir_c), 32'd3);
    chk("arb_i_data",      idat, 32'h10000001);
    chk("arb_write_cycle", 32'(wr_c), 32'd5);
    chk("arb_d_resp",      32'(dr_c), 32'd6);
    chk("arb_be",          32'(cbe), 32'hF);
    chk("arb_wdata",       cwd, 32'hF3);
    step();
    i_address = 32'h8; i_read = 1'b1;
    d_address = 32'h44; d_writedata = 32'h55; d_byteenable = 4'hF; d_write = 1'b1;
    step();
    chk("arb2_read",  32'(read), 32'd1);
    chk("arb2_write", 32'(write), 32'd0);
    drain("arb2");

    // Mid-transfer input changes must not disturb the registered command.
    stall_left = 2; waitrequest = 1'b1;
    d_address = 32'h60; d_writedata = 32'h11111111; d_byteenable = 4'hF; d_write = 1'b1;
    step();
    d_address = 32'h70; d_writedata = 32'h22222222; d_byteenable = 4'h1; d_read = 1'b1;
    i_address = 32'hC; i_read = 1'b1;
    step();
    chk("mid_addr",  address, 32'h60);
    chk("mid_wdata", writedata, 32'h11111111);
    chk("mid_be",    32'(byteenable), 32'hF);
    chk("mid_write", 32'(write), 32'd1);
    drain("mid");

    // Slave never releases: abort after 255 stall cycles.
    hang = 1'b1; waitrequest = 1'b1;
    d_address = 32'h44; d_byteenable = 4'hF; d_read = 1'b1;
    nstb = 0; berr_c = -1; berr_n = 0; dr_c = -1; ddat = 32'hX;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (read) nstb++;
      if (bus_error) begin
        berr_n++;
        if (berr_c < 0) berr_c = c;
      end
      if (!d_waitrequest) begin
        dr_c = c; ddat = d_readdata; release_all();
        break;
      end
    end
    step();
    if (bus_error) berr_n++;
    chk("to_stall_cycles", 32'(nstb), 32'd255);
    chk("to_berr_cycle",   32'(berr_c), 32'd256);
    chk("to_berr_count",   32'(berr_n), 32'd1);
    chk("to_resp_cycle",   32'(dr_c), 32'd256);
    chk("to_rdata",        ddat, 32'hDEADBEEF);
    hang = 1'b0; stall_left = 0; waitrequest = 1'b0;
    step();

    // Reset in RDATA: outputs back to reset values at once, no response later.
    i_address = 32'h8; i_read = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("rr_read",   32'(read), 32'd0);
    chk("rr_addr",   address, 32'h0);
    chk("rr_be",     32'(byteenable), 32'd0);
    chk("rr_wdata",  writedata, 32'h0);
    chk("rr_iwait",  32'(i_waitrequest), 32'd1);
    chk("rr_irdata", i_readdata, 32'h0);
    chk("rr_dwait",  32'(d_waitrequest), 32'd1);
    release_all();
    step();
    reset_n = 1'b1;
    other_low = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (!i_waitrequest) other_low = 1'b1;
    end
    chk("rr_no_resp", 32'(other_low), 32'd0);
    v = '{1'b0, 1'b0, 1'b1, 32'h00000080, 32'h0BADF00D, 4'h0, 0, 2, 32'h0, 1, 4'hF, 1'b1};
    run_txn(v, lat, rd, nstb, be_seen, wr_seen, wd_seen, nberr, other_low);
    chk("rr_after_lat", 32'(lat), 32'd2);
    chk("rr_after_be",  32'(be_seen), 32'hF);
    v = '{1'b1, 1'b0, 1'b0, 32'h00000010, 32'h0, 4'h0, 0, 3, 32'h10000004, 1, 4'hF, 1'b0};
    run_txn(v, lat, rd, nstb, be_seen, wr_seen, wd_seen, nberr, other_low);
    chk("rr_fetch_lat",  32'(lat), 32'd3);
    chk("rr_fetch_data", rd, 32'h10000004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
